// File: rtl/seg7_to_bcd_capture_if.sv
// Scan-bus / snapshot-handshake bundle for seg7_to_bcd_capture.
//   seg_in, dig_sel, seg_strobe : sampled scan bus (into the capture block)
//   out_ready                   : consumer accepts snapshot (into the capture block)
//   bcd_out, digit_err          : snapshot and per-digit illegal-pattern flags
//   out_valid                   : snapshot available
//   overrun, sel_err            : one-cycle status pulses
// Modports: slave = capture block, master = scan source / consumer side.
// DIGITS must match the DIGITS of the attached seg7_to_bcd_capture.
interface seg7_to_bcd_capture_if #(
    parameter int unsigned DIGITS = 4
);
    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   dig_sel;
    logic                seg_strobe;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   digit_err;
    logic                out_valid;
    logic                out_ready;
    logic                overrun;
    logic                sel_err;

    modport master (
        output seg_in, dig_sel, seg_strobe, out_ready,
        input  bcd_out, digit_err, out_valid, overrun, sel_err
    );

    modport slave (
        input  seg_in, dig_sel, seg_strobe, out_ready,
        output bcd_out, digit_err, out_valid, overrun, sel_err
    );
endinterface

// File: rtl/seg7_to_bcd_capture.sv
// Captures a multiplexed seven-segment scan, decodes each digit to BCD,
// debounces each digit over STABLE_CNT identical observations and offers
// a whole-display snapshot through a valid/ready handshake.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg7_to_bcd_capture_if.slave (scan bus in, snapshot out)
// Parameters: DIGITS (2..8), STABLE_CNT (1..15).
// Build option: define SEG_ACTIVE_LOW_EN to invert seg_in before decode
// (common-anode displays); only segment polarity is affected.
module seg7_to_bcd_capture #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    seg7_to_bcd_capture_if.slave     bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CNT);
    localparam logic [4:0] BLANK      = 5'h0F;   // {err, value}

    // Returns {err, value}.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = 5'h00;
            7'b0110000: decode = 5'h01;
            7'b1101101: decode = 5'h02;
            7'b1111001: decode = 5'h03;
            7'b0110011: decode = 5'h04;
            7'b1011011: decode = 5'h05;
            7'b1011111,
            7'b0011111: decode = 5'h06;
            7'b1110000: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1111011,
            7'b1110011: decode = 5'h09;
            7'b0000000: decode = 5'h0F;
            default:    decode = 5'h1E;
        endcase
    endfunction

    logic [6:0] seg_eff;
    logic       accept;
    logic       frame_end;
    logic [4:0] dec;

    always_comb begin
`ifdef SEG_ACTIVE_LOW_EN
        seg_eff = ~bus.seg_in;
`else
        seg_eff = bus.seg_in;
`endif
        dec       = decode(seg_eff);
        accept    = bus.seg_strobe && $onehot(bus.dig_sel);
        frame_end = accept && bus.dig_sel[DIGITS-1];
    end

    logic [4:0] cand_q [DIGITS];
    logic [4:0] cand_d [DIGITS];
    logic [3:0] cnt_q  [DIGITS];
    logic [3:0] cnt_d  [DIGITS];
    logic [4:0] comm_q [DIGITS];
    logic [4:0] comm_d [DIGITS];
    logic       hit;
    logic       pend_set;

    // Per-digit debounce; the commit is folded into the same cycle so the
    // frame-end decision below sees this strobe's own commit.
    always_comb begin
        pend_set = 1'b0;
        hit      = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            cand_d[i] = cand_q[i];
            cnt_d[i]  = cnt_q[i];
            comm_d[i] = comm_q[i];
            if (accept && bus.dig_sel[i]) begin
                hit = 1'b0;
                if (dec == cand_q[i]) begin
                    if (cnt_q[i] != STABLE_MAX) begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                        hit      = (cnt_d[i] == STABLE_MAX);
                    end
                end else begin
                    cand_d[i] = dec;
                    cnt_d[i]  = 4'd1;
                    hit       = (STABLE_MAX == 4'd1);
                end
                if (hit) begin
                    comm_d[i] = cand_d[i];
                    if (cand_d[i] != comm_q[i])
                        pend_set = 1'b1;
                end
            end
        end
    end

    state_t state_q, state_d;
    logic   pend_q;
    logic   pend_eff;
    logic   load;
    logic   ovr_d;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        ovr_d    = 1'b0;
        pend_eff = pend_q || pend_set;
        case (state_q)
            IDLE: begin
                if (frame_end && pend_eff) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (frame_end && pend_eff) begin
                    // A simultaneous accept frees the slot for the new snapshot.
                    if (bus.out_ready)
                        load = 1'b1;
                    else
                        ovr_d = 1'b1;
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [4*DIGITS-1:0] snap_val_d, snap_val_q;
    logic [DIGITS-1:0]   snap_err_d, snap_err_q;

    always_comb begin
        snap_val_d = '0;
        snap_err_d = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            snap_val_d[4*i +: 4] = comm_d[i][3:0];
            snap_err_d[i]        = comm_d[i][4];
        end
    end

    logic ovr_q;
    logic sel_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            snap_val_q <= '1;
            snap_err_q <= '0;
            ovr_q      <= 1'b0;
            sel_err_q  <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                cand_q[i] <= BLANK;
                cnt_q[i]  <= 4'd0;
                comm_q[i] <= BLANK;
            end
        end else begin
            state_q   <= state_d;
            pend_q    <= load ? 1'b0 : pend_eff;
            ovr_q     <= ovr_d;
            sel_err_q <= bus.seg_strobe && !$onehot(bus.dig_sel);
            if (load) begin
                snap_val_q <= snap_val_d;
                snap_err_q <= snap_err_d;
            end
            for (int unsigned i = 0; i < DIGITS; i++) begin
                cand_q[i] <= cand_d[i];
                cnt_q[i]  <= cnt_d[i];
                comm_q[i] <= comm_d[i];
            end
        end
    end

    assign bus.bcd_out   = snap_val_q;
    assign bus.digit_err = snap_err_q;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.overrun   = ovr_q;
    assign bus.sel_err   = sel_err_q;
endmodule

// File: doc/seg7_to_bcd_capture.md
# seg7_to_bcd_capture

Receiving end of the seven-segment digit interface. Samples the segment lines and one-hot digit-select of a multiplexed, scanned seven-segment display and decodes each pattern back to a BCD digit. Filters glitches by requiring a pattern to be stable over several scans before committing it. Presents a whole-display snapshot to downstream logic through a valid/ready handshake. Sits between the display scan bus (or a test tap on it) and any consumer that needs numeric readback.

## Interface
- DIGITS, 4: number of scanned digit positions (2..8).
- STABLE_CNT, 3: consecutive identical observations of a digit required before commit (1..15).
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- seg_in  input  7  segment lines; bit6=a, bit5=b, …, bit0=g; active-high.
- dig_sel  input  DIGITS  one-hot digit select; bit i = digit i, digit 0 least significant.
- seg_strobe  input  1  one-cycle qualifier: seg_in/dig_sel valid this cycle.
- bcd_out  output  4*DIGITS  snapshot; nibble i = digit i.
- digit_err  output  DIGITS  per-digit flag: snapshot nibble i came from an illegal pattern.
- out_valid  output  1  snapshot available.
- out_ready  input  1  consumer accepts snapshot.
- overrun  output  1  one-cycle pulse: a snapshot was due while the previous one was unaccepted.
- sel_err  output  1  one-cycle pulse: strobe with dig_sel not one-hot.

## Operation
- Decode on strobe: 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9. Aliases: 0011111→6, 1110011→9. 0000000→4'hF (blank). Any other pattern→4'hE with error bit set.
- Strobe with dig_sel zero or multi-hot: sample ignored, no state change, sel_err pulses.
- Per digit i: candidate (4b + err bit) and saturating stability counter. A decode equal to the candidate increments the counter, saturating at STABLE_CNT. A differing decode loads the candidate and sets counter=1.
- When the counter transitions to STABLE_CNT: the candidate is copied to committed[i]. If it differs from the old committed value, the shared pending flag is set. With STABLE_CNT=1, every new value commits on its first observation.
- Frame end = accepted strobe on digit DIGITS-1, evaluated after that strobe's own commit.
- FSM IDLE: out_valid=0. At frame end with pending: load bcd_out/digit_err from committed, clear pending, go to HOLD.
- FSM HOLD: out_valid=1, snapshot frozen. out_ready=1 → IDLE.
- HOLD, frame end with pending, out_ready=0: snapshot not replaced, pending kept, overrun pulses.
- HOLD, frame end with pending, out_ready=1 same cycle: snapshot reloaded, stay HOLD, no overrun.
- Reset (any time, including mid-frame or in HOLD): FSM IDLE; bcd_out all 4'hF; digit_err 0; out_valid 0; overrun 0; sel_err 0. Candidates are 4'hF with counter 0; committed values are 4'hF; pending is 0.

## Timing
- Inputs sampled on the rising edge where seg_strobe=1. Back-to-back strobes are legal.
- Candidate, counter and commit update on that edge.
- Latency: out_valid rises on the edge sampling the frame-end strobe, visible the following cycle.
- Minimum latency from a new stable value to snapshot: STABLE_CNT full scans.
- Handshake: transfer on the edge where out_valid=1 and out_ready=1. out_valid drops the next cycle unless reloaded.
- bcd_out and digit_err are constant while out_valid=1 and no transfer occurs.
- overrun and sel_err are registered, high exactly one cycle.

## Configuration
- SEG_ACTIVE_LOW_EN defined: seg_in is inverted before decode, for common-anode displays (all-ones = blank).
- SEG_ACTIVE_LOW_EN undefined: seg_in is active-high as listed.
- The macro does not affect dig_sel polarity or any other behaviour.

## Test plan
- Reset, then 3 full scans of digits 3..0 = 0110000, 1101101, 1111001, 0110011 (DIGITS=4, STABLE_CNT=3) → one snapshot, bcd_out=16'h1234, digit_err=0, out_valid held until out_ready.
- Digit 0 shows 1111011 for 2 scans, then 1110000 for 3 scans → no commit of 9. Snapshot nibble0=7 after the third scan of 7.
- Digit 2 pattern 1000001 stable for 3 scans → nibble2=4'hE, digit_err[2]=1. Aliases 0011111/1110011 → 6/9 with no error.
- Hold out_ready=0 through a second pending frame → overrun pulses once, bcd_out unchanged. Raise out_ready → new snapshot at next frame end.
- Strobe with dig_sel=4'b0110 → sel_err pulse, counters unchanged. Assert rst_n=0 mid-HOLD → out_valid=0, bcd_out=16'hFFFF immediately.
- With SEG_ACTIVE_LOW_EN, drive inverted patterns of 1234 → bcd_out=16'h1234.
